// File: rtl/tis_exec_node.sv
// Execute stage of one TIS-100 node: owns ACC/BAK, runs neighbour-port handshakes
// and hands PC control (pc_en/pc_op/jmp_off) back to instr_rom.
//
// state      | meaning
// FETCH      | bubble while instr_rom output settles; pc_en pulse lands here
// EXEC       | decode instr; commit, or start a port read/write
// READ_WAIT  | in_ready[src dir] high until neighbour delivers
// WRITE_WAIT | out_valid[dst dir] high until neighbour accepts
module tis_exec_node #(
    parameter int VMAX = 999,
    parameter int W    = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [20:0]    instr,
    output logic           pc_en,
    output logic [3:0]     pc_op,
    output logic [W-1:0]   acc,
    output logic [W-1:0]   jmp_off,
    input  logic [4*W-1:0] in_data,
    input  logic [3:0]     in_valid,
    output logic [3:0]     in_ready,
    output logic [W-1:0]   out_data,
    output logic [3:0]     out_valid,
    input  logic [3:0]     out_ready
);

    typedef enum logic [1:0] {FETCH, EXEC, READ_WAIT, WRITE_WAIT} state_t;

    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    localparam logic signed [W:0] VMAX_E = (W+1)'(VMAX);

    state_t state, state_nxt;
    logic signed [W-1:0] acc_q, acc_nxt, bak_q, bak_nxt;
    logic                pc_en_nxt;
    logic [3:0]          pc_op_nxt;
    logic [W-1:0]        jmp_off_nxt, out_data_nxt;

    logic [3:0]          op;
    logic [2:0]          src, dst;
    logic signed [W-1:0] imm, port_val, src_val;
    logic signed [W:0]   acc_ext, src_ext;
    logic [1:0]          src_dir, dst_dir;
    logic                src_is_port, dst_is_port, uses_src, writes_port;

    function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
        logic signed [W:0] r;
        r = x;
        if (x > VMAX_E)
            r = VMAX_E;
        else if (x < -VMAX_E)
            r = -VMAX_E;
        return r[W-1:0];
    endfunction

    assign op  = instr[20:17];
    assign src = instr[16:14];
    assign dst = instr[13:11];
    assign imm = W'($signed(instr[10:0]));

    always_comb begin
        src_is_port = 1'b1;
        src_dir     = 2'd0;
        case (src)
            3'd3: src_dir = 2'd0;
            3'd4: src_dir = 2'd1;
            3'd5: src_dir = 2'd2;
            3'd6: src_dir = 2'd3;
            default: src_is_port = 1'b0;
        endcase
        dst_is_port = 1'b1;
        dst_dir     = 2'd0;
        case (dst)
            3'd2: dst_dir = 2'd0;
            3'd3: dst_dir = 2'd1;
            3'd4: dst_dir = 2'd2;
            3'd5: dst_dir = 2'd3;
            default: dst_is_port = 1'b0;
        endcase
    end

    // Only instructions that consume a source may stall on a read port.
    assign uses_src    = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JRO);
    assign writes_port = (op == OP_MOV) && dst_is_port;
    assign port_val    = in_data[src_dir*W +: W];

    always_comb begin
        case (src)
            3'd0:    src_val = imm;
            3'd1:    src_val = acc_q;
            3'd3, 3'd4, 3'd5, 3'd6: src_val = port_val;
            default: src_val = '0;
        endcase
    end

    assign acc_ext = {acc_q[W-1], acc_q};
    assign src_ext = {src_val[W-1], src_val};

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc_q;
        bak_nxt      = bak_q;
        pc_en_nxt    = 1'b0;
        pc_op_nxt    = 4'd0;
        jmp_off_nxt  = '0;
        out_data_nxt = out_data;

        case (state)
            FETCH: state_nxt = EXEC;
            EXEC: begin
                if (uses_src && src_is_port) begin
                    state_nxt = READ_WAIT;
                end else if (writes_port) begin
                    out_data_nxt = src_val;
                    state_nxt    = WRITE_WAIT;
                end else begin
                    state_nxt = FETCH;
                    pc_en_nxt = 1'b1;
                end
            end
            READ_WAIT: begin
                if (in_valid[src_dir]) begin
                    if (writes_port) begin
                        out_data_nxt = port_val;
                        state_nxt    = WRITE_WAIT;
                    end else begin
                        state_nxt = FETCH;
                        pc_en_nxt = 1'b1;
                    end
                end
            end
            WRITE_WAIT: begin
                if (out_ready[dst_dir]) begin
                    state_nxt = FETCH;
                    pc_en_nxt = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase

        // A pc_en pulse out of EXEC/READ_WAIT is exactly the commit point.
        if (pc_en_nxt && state != WRITE_WAIT) begin
            case (op)
                OP_MOV: if (dst == 3'd0) acc_nxt = sat(src_ext);
                OP_SWP: begin
                    acc_nxt = bak_q;
                    bak_nxt = acc_q;
                end
                OP_SAV: bak_nxt = acc_q;
                OP_ADD: acc_nxt = sat(acc_ext + src_ext);
                OP_SUB: acc_nxt = sat(acc_ext - src_ext);
                OP_NEG: acc_nxt = sat(-acc_ext);
                OP_JRO: begin
                    pc_op_nxt   = op;
                    jmp_off_nxt = src_val;
                end
                default: begin
                    if (op >= OP_JMP && op <= OP_JLZ) begin
                        pc_op_nxt   = op;
                        jmp_off_nxt = imm;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            acc_q    <= '0;
            bak_q    <= '0;
            pc_en    <= 1'b0;
            pc_op    <= 4'd0;
            jmp_off  <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            acc_q    <= acc_nxt;
            bak_q    <= bak_nxt;
            pc_en    <= pc_en_nxt;
            pc_op    <= pc_op_nxt;
            jmp_off  <= jmp_off_nxt;
            out_data <= out_data_nxt;
        end
    end

    assign acc       = acc_q;
    assign in_ready  = (state == READ_WAIT)  ? (4'b0001 << src_dir) : 4'b0000;
    assign out_valid = (state == WRITE_WAIT) ? (4'b0001 << dst_dir) : 4'b0000;

endmodule
